// File: rtl/home_cell_ref_scheduler.sv
// Home-cell pass sequencer: reads the particle count, then streams every home particle
// twice (phase 0/1) per reference particle, with control tags aligned to memory read data.
module home_cell_ref_scheduler #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stall,
  input  logic [PARTICLE_ID_WIDTH-1:0] rd_cnt,
  output logic                         rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
  output logic                         reading_particle_num,
  output logic                         valid_o,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id,
  output logic [PARTICLE_ID_WIDTH-1:0] ref_id,
  output logic                         phase,
  output logic                         prev_phase,
  output logic                         busy,
  output logic                         done
);
  localparam int W  = PARTICLE_ID_WIDTH;
  localparam int DW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_CNT, S_WAIT_CNT, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic         vld;
    logic         cnt;
    logic [W-1:0] k;
    logic [W-1:0] r;
    logic         ph;
  } tag_t;

  state_t       state_q, state_d;
  logic [W-1:0] k_q, k_d, r_q, r_d, cnt_q, cnt_d;
  logic         ph_q, ph_d;
  logic [DW-1:0] drn_q, drn_d;
  logic         prev_phase_q;

  tag_t tag_d;
  tag_t [RD_LATENCY-1:0] pipe_q;
  tag_t shin [RD_LATENCY];
  tag_t last_d;

  assign rd_en                = !stall;
  assign reading_particle_num = pipe_q[RD_LATENCY-1].cnt;
  assign valid_o              = pipe_q[RD_LATENCY-1].vld;
  assign particle_id          = pipe_q[RD_LATENCY-1].k;
  assign ref_id               = pipe_q[RD_LATENCY-1].r;
  assign phase                = pipe_q[RD_LATENCY-1].ph;
  assign prev_phase           = prev_phase_q;
  assign busy = (state_q == S_RD_CNT) || (state_q == S_WAIT_CNT) ||
                (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    r_d     = r_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    tag_d   = '0;
    rd_addr = '0;
    case (state_q)
      S_IDLE: if (start) state_d = S_RD_CNT;
      S_RD_CNT: begin
        tag_d.cnt = 1'b1;
        state_d   = S_WAIT_CNT;
      end
      S_WAIT_CNT: if (reading_particle_num) begin
        cnt_d   = rd_cnt;
        k_d     = {{(W-1){1'b0}}, 1'b1};
        r_d     = {{(W-1){1'b0}}, 1'b1};
        ph_d    = 1'b0;
        state_d = (rd_cnt == '0) ? S_DONE : S_STREAM;
      end
      S_STREAM: begin
        rd_addr   = k_q;
        tag_d.vld = 1'b1;
        tag_d.k   = k_q;
        tag_d.r   = r_q;
        tag_d.ph  = ph_q;
        // k and r never pass count, so a full-scale count cannot wrap
        if (k_q < cnt_q) begin
          k_d = k_q + 1'b1;
        end else if (!ph_q) begin
          ph_d = 1'b1;
          k_d  = {{(W-1){1'b0}}, 1'b1};
        end else if (r_q < cnt_q) begin
          r_d  = r_q + 1'b1;
          ph_d = 1'b0;
          k_d  = {{(W-1){1'b0}}, 1'b1};
        end else begin
          drn_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drn_q == DW'(RD_LATENCY - 1)) state_d = S_DONE;
        else                              drn_d   = drn_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Final delay stage keeps id/ref/phase when no valid tag arrives
  always_comb begin
    shin[0] = tag_d;
    for (int i = 1; i < RD_LATENCY; i++) shin[i] = pipe_q[i-1];
    last_d     = pipe_q[RD_LATENCY-1];
    last_d.vld = shin[RD_LATENCY-1].vld;
    last_d.cnt = shin[RD_LATENCY-1].cnt;
    if (shin[RD_LATENCY-1].vld) last_d = shin[RD_LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      r_q          <= '0;
      ph_q         <= 1'b0;
      cnt_q        <= '0;
      drn_q        <= '0;
      pipe_q       <= '0;
      prev_phase_q <= 1'b0;
    end else if (!stall) begin
      state_q      <= state_d;
      k_q          <= k_d;
      r_q          <= r_d;
      ph_q         <= ph_d;
      cnt_q        <= cnt_d;
      drn_q        <= drn_d;
      for (int i = 0; i < RD_LATENCY - 1; i++) pipe_q[i] <= shin[i];
      pipe_q[RD_LATENCY-1] <= last_d;
      prev_phase_q <= pipe_q[RD_LATENCY-1].ph;
    end
  end
endmodule
